seg7_scan_driver: RTL and testbench

- Multiplexed 7-segment display driver; consumes the refresh sequencing produced by the counter stage and drives the Nexys-style common-anode display.
- Latches a packed hex value, then scans one digit per refresh tick.
- Supports leading-zero blanking, per-digit decimal points and inter-digit ghosting guard.
- Display updates are frame-synchronous, so the display never tears.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/pulse_prescaler.sv | 34 +++
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared types, constants and hex decoder for the 7-segment driver.
// Revision: 1.0
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low cathode pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : pulse_prescaler
// Brief   : Free-running divider emitting a one-cycle tick every PRESCALE clocks.
// Revision: 1.0
// ============================================================================
module pulse_prescaler #(
    parameter int PRESCALE = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int            CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_last = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Frame-synchronous multiplexed common-anode 7-segment scan driver.
// Revision: 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int PRESCALE = 100000,
    parameter int GUARD    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  blank_lz,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   anodes,
    output logic                  frame_start
);

    localparam int            IW          = $clog2(N_DIGITS);
    localparam int            GW          = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [IW-1:0] c_last_idx  = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] c_idx_one   = IW'(1);
    localparam logic [GW-1:0] c_guard     = GW'(GUARD);
    localparam logic [GW-1:0] c_guard_one = GW'(1);

    logic                  w_tick;
    logic                  w_commit;
    logic [IW-1:0]         r_idx;
    logic [GW-1:0]         r_guard;
    logic [4*N_DIGITS-1:0] r_shadow_value;
    logic [N_DIGITS-1:0]   r_shadow_dp;
    logic [4*N_DIGITS-1:0] r_disp_value;
    logic [N_DIGITS-1:0]   r_disp_dp;
    logic [N_DIGITS-1:0]   r_anodes;
    seg_t                  r_segments;
    logic                  r_dp;
    logic                  r_frame_start;

    logic [3:0]            w_cur_digit;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic                  w_tail_zero;
    logic [N_DIGITS-1:0]   w_sel;

    pulse_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_commit = w_tick && (r_idx == c_last_idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_guard <= '0;
        end else begin
            if (w_tick) begin
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_one;
            end
            if (w_tick) begin
                r_guard <= c_guard;
            end else if (r_guard != '0) begin
                r_guard <= r_guard - c_guard_one;
            end
        end
    end

    // Display only ever takes the shadow at a frame boundary, so a load that
    // coincides with the commit tick waits one more frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_disp_value   <= '0;
            r_disp_dp      <= '0;
            r_frame_start  <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_value <= value;
                r_shadow_dp    <= dp_mask;
            end
            if (w_commit) begin
                r_disp_value <= r_shadow_value;
                r_disp_dp    <= r_shadow_dp;
            end
            r_frame_start <= w_commit;
        end
    end

    // Walk from the most significant digit down so the running all-zero flag
    // tells whether the current digit and everything above it are zero.
    always_comb begin
        w_cur_digit = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        w_tail_zero = 1'b1;
        w_sel       = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_tail_zero = w_tail_zero && (r_disp_value[4*k +: 4] == 4'h0);
            if (int'(r_idx) == k) begin
                w_cur_digit = r_disp_value[4*k +: 4];
                w_cur_dp    = r_disp_dp[k];
                w_cur_blank = blank_lz && (k != 0) && w_tail_zero;
                w_sel[k]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_anodes   <= '1;
            r_segments <= SEG_OFF;
            r_dp       <= 1'b1;
        end else begin
            r_anodes   <= ((r_guard == '0) && !w_cur_blank) ? ~w_sel : '1;
            r_segments <= w_cur_blank ? SEG_OFF : hex_to_seg(w_cur_digit);
            r_dp       <= w_cur_blank ? 1'b1 : ~w_cur_dp;
        end
    end

    assign anodes      = r_anodes;
    assign segments    = r_segments;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Self-checking bench: per-cycle reference model, vector table, corners.
// Revision: 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int P = 4;
    localparam int FRAME = N * P;
    localparam logic [3:0] ONE4 = 4'b0001;
    localparam logic [6:0] LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] value    = '0;
    logic [3:0]  dp_mask  = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_start;

    seg7_scan_driver #(
        .N_DIGITS (N),
        .PRESCALE (P),
        .GUARD    (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_lz    (blank_lz),
        .segments    (segments),
        .dp          (dp),
        .anodes      (anodes),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int errors   = 0;
    int fs_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: e counts clock edges since reset release; the scan
    // position, guard window and frame boundary all follow from e arithmetically.
    int          e        = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp   = '0;
    logic [3:0]  m_sdp    = '0;
    logic [3:0]  m_ddp    = '0;
    logic [3:0]  x_an     = 4'hF;
    logic [6:0]  x_seg    = 7'h7F;
    logic        x_dp     = 1'b1;
    logic        x_fs     = 1'b0;

    always @(posedge clock or negedge reset) begin : model
        int   ip;
        bit   gp;
        bit   blk;
        bit   commit;
        if (!reset) begin
            e = 0; m_shadow = '0; m_disp = '0; m_sdp = '0; m_ddp = '0;
            x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1; x_fs = 1'b0;
        end else begin
            ip     = (e / P) % N;
            gp     = (e >= P) && (e % P == 0);
            blk    = blank_lz && (ip != 0) && ((m_disp >> (4 * ip)) == 16'h0);
            x_an   = (!gp && !blk) ? ~(ONE4 << ip) : 4'hF;
            x_seg  = blk ? 7'h7F : LUT[m_disp[4*ip +: 4]];
            x_dp   = blk ? 1'b1 : ~m_ddp[ip];
            commit = ((e + 1) % P == 0) && (ip == N - 1);
            x_fs   = commit;
            if (commit) begin
                m_disp = m_shadow;
                m_ddp  = m_sdp;
            end
            if (load) begin
                m_shadow = value;
                m_sdp    = dp_mask;
            end
            e++;
        end
    end

    always @(negedge clock) begin
        check("model anodes", 32'(anodes), 32'(x_an));
        check("model segments", 32'(segments), 32'(x_seg));
        check("model dp", 32'(dp), 32'(x_dp));
        check("model frame_start", 32'(frame_start), 32'(x_fs));
    end

    task automatic wait_phase(input int md, input int ph);
        int n = 0;
        while ((e % md) != ph && n < 500) begin
            @(negedge clock);
            n++;
        end
        if ((e % md) != ph) begin
            checks++;
            errors++;
            $display("FAIL wait_phase timeout: got phase %0d, expected %0d", e % md, ph);
        end
    endtask

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpm;
        logic        blz;
        logic [27:0] seg;   // slot k at [7k+:7]
        logic [15:0] an;    // slot k at [4k+:4]
        logic [3:0]  dpx;   // slot k at [k]
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 16'h7BDE, 4'b1111};
        tbl[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 16'hFFFE, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE, 4'b1111};
        tbl[3] = '{16'h8888, 4'b0101, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}, 16'h7BDE, 4'b1010};
        tbl[4] = '{16'hABCD, 4'b1010, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}, 16'h7BDE, 4'b0101};
        tbl[5] = '{16'h0E0F, 4'b1000, 1'b1, {7'h7F, 7'h06, 7'h40, 7'h0E}, 16'hFBDE, 4'b1111};
        tbl[6] = '{16'h0560, 4'b0000, 1'b0, {7'h40, 7'h12, 7'h02, 7'h40}, 16'h7BDE, 4'b1111};
        tbl[7] = '{16'h0090, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h10, 7'h40}, 16'hFFDE, 4'b1100};

        // Reset held low: outputs dark.
        repeat (3) @(negedge clock);
        check("reset anodes", 32'(anodes), 32'h F);
        check("reset segments", 32'(segments), 32'h7F);
        check("reset dp", 32'(dp), 32'h1);
        check("reset frame_start", 32'(frame_start), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Pre-commit digit 0 shows zero; load 1234 early in the first frame.
        wait_phase(1000, 2);
        check("precommit anodes", 32'(anodes), 32'hE);
        check("precommit segments", 32'(segments), 32'h40);
        value = 16'h1234; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_phase(1000, 4);
        check("before first tick anodes", 32'(anodes), 32'hE);
        wait_phase(1000, 5);
        check("first guard anodes", 32'(anodes), 32'hF);
        wait_phase(1000, 17);
        check("commit guard anodes", 32'(anodes), 32'hF);
        wait_phase(1000, 18);
        check("digit0 anodes", 32'(anodes), 32'hE);
        check("digit0 segments", 32'(segments), 32'h19);
        wait_phase(1000, 23);
        check("digit1 anodes", 32'(anodes), 32'hD);
        check("digit1 segments", 32'(segments), 32'h30);

        fs_count = 0;
        repeat (4 * FRAME) begin
            @(negedge clock);
            if (frame_start) fs_count++;
        end
        check("frame_start count", 32'(fs_count), 32'd4);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            wait_phase(FRAME, 5);
            value = tbl[i].value; dp_mask = tbl[i].dpm; blank_lz = tbl[i].blz; load = 1'b1;
            @(negedge clock);
            load = 1'b0;
            wait_phase(FRAME, 1);
            for (int k = 0; k < N; k++) begin
                wait_phase(FRAME, P * k + 3);
                check($sformatf("vec%0d slot%0d anodes", i, k), 32'(anodes), 32'(tbl[i].an[4*k +: 4]));
                check($sformatf("vec%0d slot%0d segments", i, k), 32'(segments), 32'(tbl[i].seg[7*k +: 7]));
                check($sformatf("vec%0d slot%0d dp", i, k), 32'(dp), 32'(tbl[i].dpx[k]));
            end
        end

        // Load coincident with the commit tick lands one frame late.
        blank_lz = 1'b0; dp_mask = 4'b0000;
        wait_phase(FRAME, 5);
        value = 16'h1234; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_phase(FRAME, 15);
        @(negedge clock);
        wait_phase(FRAME, 15);
        value = 16'hABCD; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_phase(FRAME, 3);
        check("collision old frame segments", 32'(segments), 32'h19);
        @(negedge clock);
        wait_phase(FRAME, 3);
        check("collision new frame segments", 32'(segments), 32'h21);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            load    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       value = 16'($urandom);
                1:       value = 16'($urandom) & 16'h00FF;
                2:       value = 16'($urandom) & 16'h000F;
                default: value = 16'h0000;
            endcase
            dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clock);
        load = 1'b0; blank_lz = 1'b0; value = 16'h8888;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (2 * FRAME) @(negedge clock);

        // Mid-frame asynchronous reset while digit 2 is lit.
        wait_phase(FRAME, 10);
        check("pre-reset digit2 anodes", 32'(anodes), 32'hB);
        #2 reset = 1'b0;
        #1;
        check("async reset anodes", 32'(anodes), 32'hF);
        check("async reset segments", 32'(segments), 32'h7F);
        check("async reset dp", 32'(dp), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        wait_phase(1000, 2);
        check("restart anodes", 32'(anodes), 32'hE);
        check("restart segments", 32'(segments), 32'h40);
        check("restart dp", 32'(dp), 32'h1);
        repeat (FRAME + 2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
